// File: rtl/north_gdma_pkg.sv
// Shared definitions for the north GDMA path: AXI constants, the read-address
// FSM state type and the DDR page size used for 4 KB burst splitting.
package north_gdma_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         PAGE_BYTES     = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADDR = 2'd2
    } raddr_state_t;

    // Unsigned minimum of two beat counts.
    function automatic logic [30:0] min_beats(input logic [30:0] a, input logic [30:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/north_raddr_burst_calc.sv
// Combinational burst sizer for north_raddr: picks the beat count of the next
// AR burst from the remaining beats, MAX_BURST and (optionally) the distance
// to the next 4 KB page.
// Configuration macro: NORTH_RADDR_4K_SPLIT_EN -- when defined, bursts are
// clipped at 4 KB page boundaries; when undefined, only MAX_BURST applies.
module north_raddr_burst_calc
    import north_gdma_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [31:0] addr_q,
    input  logic [30:0] beats_left,
    output logic [8:0]  beats
);

    localparam logic [30:0] MAX_BURST_W = 31'(MAX_BURST);

    logic [30:0] cap_burst;
    logic [30:0] beats_full;
    logic        unused_bits;

    assign cap_burst = min_beats(beats_left, MAX_BURST_W);

`ifdef NORTH_RADDR_4K_SPLIT_EN
    // Words left before the page boundary: 1..1024, never zero since addr is word aligned.
    logic [12:0] bytes_to_4k;
    logic [30:0] beats_to_4k;

    assign bytes_to_4k = 13'(PAGE_BYTES) - {1'b0, addr_q[11:0]};
    assign beats_to_4k = 31'(bytes_to_4k[12:2]);
    assign beats_full  = min_beats(cap_burst, beats_to_4k);
    assign unused_bits = ^{addr_q[31:12], bytes_to_4k[1:0], beats_full[30:9]};
`else
    // Controller tolerates page crossings, so no page term.
    assign beats_full  = cap_burst;
    assign unused_bits = ^{addr_q, beats_full[30:9]};
`endif

    // Result never exceeds MAX_BURST (<= 256), so 9 bits hold it.
    assign beats = beats_full[8:0];

endmodule

// File: rtl/north_raddr.sv
// North GDMA read-address stage: turns (base_addr, length) into a sequence of
// AXI4 INCR read bursts, throttled by an outstanding-burst counter that is
// credited back on R-channel rlast handshakes.
// Configuration macro: NORTH_RADDR_4K_SPLIT_EN (applied in north_raddr_burst_calc).
module north_raddr
    import north_gdma_pkg::*;
#(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_start,
    input  logic [31:0] base_addr,
    input  logic [31:0] length,
    output logic        gdma_addr_done,
    output logic [31:0] gdma_ddr_araddr,
    output logic [7:0]  gdma_ddr_arlen,
    output logic [2:0]  gdma_ddr_arsize,
    output logic [1:0]  gdma_ddr_arburst,
    output logic        gdma_ddr_arvalid,
    input  logic        gdma_ddr_arready,
    input  logic        gdma_ddr_rvalid,
    input  logic        gdma_ddr_rready,
    input  logic        gdma_ddr_rlast
);

    raddr_state_t state_q;
    logic [31:0]  addr_q;
    logic [30:0]  beats_left_q;
    logic [8:0]   beats_q;
    logic [3:0]   outst_q, outst_d;
    logic         arvalid_q;
    logic [31:0]  araddr_q;
    logic [7:0]   arlen_q;
    logic         done_q;

    logic [8:0]   calc_beats;
    logic [30:0]  beats_left_nxt;
    logic         ar_hs, rlast_hs, slot_free;
    logic         unused_bits;

    assign ar_hs          = arvalid_q & gdma_ddr_arready;
    assign rlast_hs       = gdma_ddr_rvalid & gdma_ddr_rready & gdma_ddr_rlast;
    assign slot_free      = outst_q < 4'(MAX_OUTSTANDING);
    assign beats_left_nxt = beats_left_q - 31'(beats_q);
    assign unused_bits    = ^{base_addr[1:0], length[1:0]};

    north_raddr_burst_calc #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr_q     (addr_q),
        .beats_left (beats_left_q),
        .beats      (calc_beats)
    );

    // Outstanding bursts: +1 per AR handshake, -1 per rlast; a stray rlast at 0 is dropped.
    always_comb begin
        outst_d = outst_q;
        if (ar_hs && !(rlast_hs && outst_q != 4'd0))
            outst_d = outst_q + 4'd1;
        else if (!ar_hs && rlast_hs && outst_q != 4'd0)
            outst_d = outst_q - 4'd1;
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst_q <= 4'd0;
        else        outst_q <= outst_d;
    end

    // Address FSM; all AR outputs are registered here so arready never reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            beats_left_q <= 31'd0;
            beats_q      <= 9'd0;
            arvalid_q    <= 1'b0;
            araddr_q     <= 32'd0;
            arlen_q      <= 8'd0;
            done_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        addr_q       <= {base_addr[31:2], 2'b00};
                        beats_left_q <= {1'b0, length[31:2]} + 31'd1;
                        done_q       <= 1'b0;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    if (slot_free) begin
                        araddr_q  <= addr_q;
                        arlen_q   <= 8'(calc_beats - 9'd1);
                        beats_q   <= calc_beats;
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (gdma_ddr_arready) begin
                        arvalid_q    <= 1'b0;
                        addr_q       <= addr_q + {21'd0, beats_q, 2'b00};
                        beats_left_q <= beats_left_nxt;
                        if (beats_left_nxt == 31'd0) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gdma_addr_done   = done_q;
    assign gdma_ddr_araddr  = araddr_q;
    assign gdma_ddr_arlen   = arlen_q;
    assign gdma_ddr_arsize  = AXI_SIZE_4B;
    assign gdma_ddr_arburst = AXI_BURST_INCR;
    assign gdma_ddr_arvalid = arvalid_q;

endmodule

// File: tb/tb_north_raddr.sv
// Self-checking bench for north_raddr: directed scenarios plus randomized
// transfers checked against a transaction-level burst list and an
// outstanding-burst count kept by the bench.
module tb_north_raddr;

    localparam int MB = 16;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] length = '0;
    logic        done;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready = 1'b0;
    logic        rlast = 1'b0;

    int checks = 0;
    int errors = 0;
    int m_out  = 0;
    int hs_cnt = 0;
    logic [31:0] hs_addr[$];
    logic [7:0]  hs_len[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];

    north_raddr #(.MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .op_start         (op_start),
        .base_addr        (base_addr),
        .length           (length),
        .gdma_addr_done   (done),
        .gdma_ddr_araddr  (araddr),
        .gdma_ddr_arlen   (arlen),
        .gdma_ddr_arsize  (arsize),
        .gdma_ddr_arburst (arburst),
        .gdma_ddr_arvalid (arvalid),
        .gdma_ddr_arready (arready),
        .gdma_ddr_rvalid  (rvalid),
        .gdma_ddr_rready  (rready),
        .gdma_ddr_rlast   (rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Advance one clock; track AR handshakes and outstanding bursts from the driven inputs.
    task automatic step();
        bit hs, rl;
        hs = arvalid && arready;
        rl = rvalid && rready && rlast;
        if (hs) begin
            hs_cnt++;
            hs_addr.push_back(araddr);
            hs_len.push_back(arlen);
        end
        if (hs && !(rl && m_out > 0)) m_out++;
        else if (!hs && rl && m_out > 0) m_out--;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_track();
        m_out = 0;
        hs_cnt = 0;
        hs_addr.delete();
        hs_len.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        op_start = 1'b0; arready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_track();
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] l);
        base_addr = b;
        length = l;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
    endtask

    // Let everything finish: accept addresses, return rlast for every outstanding burst.
    task automatic drain();
        bit ok = 0;
        arready = 1'b1; rvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rlast = (m_out > 0);
            if (done && m_out == 0 && !arvalid) begin ok = 1; break; end
            step();
        end
        rlast = 1'b0; rvalid = 1'b0; rready = 1'b0; arready = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL drain_timeout got m_out=%0d done=%0b want idle", m_out, done); end
    endtask

    // Reference burst list: greedy split of the beat count by MAX_BURST and page boundaries.
    task automatic build_exp(input logic [31:0] b, input logic [31:0] l);
        longint a, left, n;
        exp_addr.delete();
        exp_len.delete();
        a = longint'(b) & 64'hFFFF_FFFC;
        left = longint'(l >> 2) + 1;
        while (left > 0) begin
            n = (left < MB) ? left : MB;
`ifdef NORTH_RADDR_4K_SPLIT_EN
            if (n > (4096 - (a % 4096)) / 4) n = (4096 - (a % 4096)) / 4;
`endif
            exp_addr.push_back(a[31:0]);
            exp_len.push_back(8'(n - 1));
            a = (a + n * 4) & 64'hFFFF_FFFF;
            left -= n;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done got %b want 1", done); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
        checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr got %h want 0", araddr); end
        checks++; if (arlen !== 8'd0) begin errors++; $display("FAIL reset_arlen got %0d want 0", arlen); end
        checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL arsize got %b want 010", arsize); end
        checks++; if (arburst !== 2'b01) begin errors++; $display("FAIL arburst got %b want 01", arburst); end
    endtask

    task automatic test_single();
        do_reset();
        arready = 1'b1;
        start(32'h1000, 32'h3C);
        checks++; if (arvalid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_c1 got v=%b d=%b want v=0 d=0", arvalid, done); end
        step();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h1000 || arlen !== 8'd15) begin
            errors++; $display("FAIL single_c2 got v=%b a=%h l=%0d want v=1 a=1000 l=15", arvalid, araddr, arlen); end
        step();
        checks++; if (arvalid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL single_c3 got v=%b d=%b want v=0 d=1", arvalid, done); end
        checks++; if (hs_cnt != 1) begin errors++; $display("FAIL single_count got %0d want 1", hs_cnt); end
        drain();
    endtask

    task automatic test_4k();
        do_reset();
        arready = 1'b1;
        start(32'h0FF0, 32'h1C);
        for (int c = 0; c < 30 && !done; c++) step();
`ifdef NORTH_RADDR_4K_SPLIT_EN
        checks++; if (hs_cnt != 2) begin errors++; $display("FAIL split_count got %0d want 2", hs_cnt); end
        else begin
            checks++; if (hs_addr[0] !== 32'h0FF0 || hs_len[0] !== 8'd3 || hs_addr[1] !== 32'h1000 || hs_len[1] !== 8'd3) begin
                errors++; $display("FAIL split_bursts got %h/%0d %h/%0d want 0ff0/3 1000/3", hs_addr[0], hs_len[0], hs_addr[1], hs_len[1]); end
        end
`else
        checks++; if (hs_cnt != 1) begin errors++; $display("FAIL nosplit_count got %0d want 1", hs_cnt); end
        else begin
            checks++; if (hs_addr[0] !== 32'h0FF0 || hs_len[0] !== 8'd7) begin
                errors++; $display("FAIL nosplit_burst got %h/%0d want 0ff0/7", hs_addr[0], hs_len[0]); end
        end
`endif
        drain();
    endtask

    task automatic test_outstanding();
        do_reset();
        arready = 1'b1;
        start(32'h0, 32'h1FC);
        repeat (30) step();
        checks++; if (hs_cnt != 4 || arvalid !== 1'b0) begin errors++; $display("FAIL outst_limit got hs=%0d v=%b want hs=4 v=0", hs_cnt, arvalid); end
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        step();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL outst_n1 got v=%b want 0", arvalid); end
        step();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h100 || arlen !== 8'd15) begin
            errors++; $display("FAIL outst_n2 got v=%b a=%h l=%0d want v=1 a=100 l=15", arvalid, araddr, arlen); end
        drain();
    endtask

    task automatic test_same_cycle();
        do_reset();
        arready = 1'b1;
        start(32'h0, 32'h1FC);
        for (int c = 0; c < 30; c++) begin
            rlast = arvalid && hs_cnt == 2;
            rvalid = rlast; rready = rlast;
            step();
        end
        rlast = 1'b0; rvalid = 1'b0; rready = 1'b0;
        checks++; if (hs_cnt != 5 || arvalid !== 1'b0) begin errors++; $display("FAIL same_cycle got hs=%0d v=%b want hs=5 v=0", hs_cnt, arvalid); end
        drain();
    endtask

    task automatic test_stray();
        do_reset();
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        step();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        step();
        arready = 1'b1;
        start(32'h0, 32'h1FC);
        repeat (30) step();
        checks++; if (hs_cnt != 4 || arvalid !== 1'b0) begin errors++; $display("FAIL stray_rlast got hs=%0d v=%b want hs=4 v=0", hs_cnt, arvalid); end
        drain();
    endtask

    task automatic test_stall();
        bit ok = 1;
        do_reset();
        start(32'h2000, 32'h7C);
        step();
        for (int i = 0; i < 10; i++) begin
            if (arvalid !== 1'b1 || araddr !== 32'h2000 || arlen !== 8'd15) ok = 0;
            op_start = (i == 3);
            base_addr = 32'h5000;
            step();
        end
        op_start = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_hold got v=%b a=%h l=%0d want v=1 a=2000 l=15", arvalid, araddr, arlen); end
        arready = 1'b1;
        for (int c = 0; c < 30 && !done; c++) step();
        checks++; if (hs_cnt != 2 || hs_addr[0] !== 32'h2000 || hs_addr[1] !== 32'h2040) begin
            errors++; $display("FAIL stall_bursts got hs=%0d want 2 bursts at 2000,2040", hs_cnt); end
        repeat (6) step();
        checks++; if (hs_cnt != 2 || arvalid !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL stall_ignored_start got hs=%0d v=%b d=%b want hs=2 v=0 d=1", hs_cnt, arvalid, done); end
        drain();
    endtask

    // Random arready/rlast; each handshake is compared with the reference burst list.
    task automatic run_xfer(input logic [31:0] b, input logic [31:0] l, input string tag);
        int nexp, got;
        bit finished = 0, prev_stall = 0, rl;
        logic [31:0] sa;
        logic [7:0]  sl;
        build_exp(b, l);
        nexp = exp_addr.size();
        got = 0;
        start(b, l);
        for (int c = 0; c < 5000; c++) begin
            if (prev_stall) begin
                checks++; if (arvalid !== 1'b1 || araddr !== sa || arlen !== sl) begin
                    errors++; $display("FAIL %s_stable got v=%b a=%h l=%0d want v=1 a=%h l=%0d", tag, arvalid, araddr, arlen, sa, sl); end
            end
            if (got < nexp) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_early got %b want 0", tag, done); end
            end else begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done_late got %b want 1", tag, done); end
                finished = 1;
                break;
            end
            if (arvalid) begin
                checks++; if (m_out >= MO) begin errors++; $display("FAIL %s_outst got %0d want <%0d", tag, m_out, MO); end
            end
            arready = ($urandom_range(0, 3) != 0);
            rl = (m_out > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
            rvalid = rl; rready = rl; rlast = rl;
            if (arvalid && arready) begin
                checks++;
                if (exp_addr.size() == 0) begin errors++; $display("FAIL %s_extra got a=%h want none", tag, araddr); end
                else begin
                    if (araddr !== exp_addr[0] || arlen !== exp_len[0]) begin
                        errors++; $display("FAIL %s_burst%0d got a=%h l=%0d want a=%h l=%0d", tag, got, araddr, arlen, exp_addr[0], exp_len[0]); end
                    void'(exp_addr.pop_front());
                    void'(exp_len.pop_front());
                end
                got++;
            end
            prev_stall = arvalid && !arready;
            sa = araddr;
            sl = arlen;
            step();
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        checks++; if (!finished) begin errors++; $display("FAIL %s_timeout got %0d bursts want %0d", tag, got, nexp); end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        start(32'h3000, 32'h3C);
        step();
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got v=%b want 1", arvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0 || done !== 1'b1 || araddr !== 32'd0) begin
            errors++; $display("FAIL rstmid_async got v=%b d=%b a=%h want v=0 d=1 a=0", arvalid, done, araddr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_track();
        run_xfer(32'h3000, 32'h3C, "rstmid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] b, l;
            b = $urandom;
            if (i % 3 == 0) b = {b[31:12], 12'hFC0} | (b & 32'h3F);
            l = ($urandom_range(0, 300) << 2) | ($urandom & 32'h3);
            run_xfer(b, l, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_4k();
        test_outstanding();
        test_same_cycle();
        test_stray();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/north_raddr.md
# north_raddr

Read-address stage of the north GDMA path. It sits directly upstream of the read-data/packaging stage. On `op_start` it converts a base address and byte length into a sequence of AXI4 INCR read bursts on the DDR AR channel. It limits the number of outstanding bursts by tracking `rlast` on the R channel, and asserts `gdma_addr_done` once the final burst address has been accepted; the read-data stage combines that flag with its own data-done flag to form `gdma_done`.

## Interface
Parameters:
- `MAX_BURST`, 16: maximum beats per burst, 1..256.
- `MAX_OUTSTANDING`, 4: maximum accepted-but-incomplete bursts, 1..15.

Ports:
- `clk`  in  1: single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `op_start`  in  1: one-cycle start pulse; sampled only in IDLE.
- `base_addr`  in  32: byte start address; bits [1:0] ignored and forced to 0.
- `length`  in  32: transfer size; total beats = `length[31:2] + 1`, the same encoding the read-data stage uses.
- `gdma_addr_done`  out  1: high when no transfer is being addressed; low from start until the last AR handshake.
- `gdma_ddr_araddr`  out  32: burst byte address.
- `gdma_ddr_arlen`  out  8: beats minus 1.
- `gdma_ddr_arsize`  out  3: constant 3'b010 (4 bytes).
- `gdma_ddr_arburst`  out  2: constant 2'b01 (INCR).
- `gdma_ddr_arvalid`  out  1: address valid.
- `gdma_ddr_arready`  in  1: address ready.
- `gdma_ddr_rvalid`, `gdma_ddr_rready`, `gdma_ddr_rlast`  in  1 each: R-channel monitor, used only for outstanding-burst accounting.

## Operation
- FSM states and transitions:
  - IDLE: `op_start` goes to CALC.
  - CALC: when `outstanding < MAX_OUTSTANDING`, computes the next burst and goes to ADDR; otherwise stays in CALC.
  - ADDR: holds `arvalid` high until `arready`. On the handshake, goes to IDLE if `beats_left` is now 0, else back to CALC.
- On `op_start`: `addr_q <= {base_addr[31:2],2'b00}`, `beats_left <= length[31:2] + 1` (31-bit, no overflow), `gdma_addr_done <= 0`.
- Burst size: `beats = min(beats_left, MAX_BURST, beats_to_4k)`, where `beats_to_4k = (4096 - addr_q[11:0]) >> 2`, range 1..1024.
- `arlen = beats - 1`. On the handshake: `addr_q += beats*4` and `beats_left -= beats`.
- Bursts never cross a 4 KB boundary, subject to the configuration macro below.
- Outstanding counter (4 bits):
  - +1 on an AR handshake.
  - −1 on `rvalid & rready & rlast`.
  - Both events in the same cycle leave it unchanged.
  - The counter never underflows; a stray `rlast` at 0 is ignored.
- `gdma_addr_done` is set to 1 in the cycle after the final AR handshake. It does not wait for data.
- `op_start` outside IDLE is ignored. An in-flight transfer is never aborted, because the AXI rule requires `arvalid` to be held until `arready`.
- Reset values: `gdma_addr_done = 1`, `arvalid = 0`, `araddr = 0`, `arlen = 0`, outstanding = 0, state = IDLE.
- Reset mid-burst drops `arvalid` immediately; the downstream stage is reset on the same reset.

## Timing
- `op_start` in cycle 0: CALC in cycle 1, `arvalid` and address registered in cycle 2.
- All AR outputs are driven from registers; no combinational path runs from `arready` to AR outputs.
- Minimum gap: after a handshake in cycle n, the next `arvalid` rises in cycle n+2 (one CALC cycle). Peak rate is one burst per 2 cycles.
- `araddr` and `arlen` are stable while `arvalid` is high and `arready` is low.
- `gdma_addr_done` rises in cycle n+1 after the final handshake in cycle n.
- An `rlast` handshake in cycle n frees a slot visible to CALC in cycle n+1.

## Configuration
- `NORTH_RADDR_4K_SPLIT_EN`:
  - Defined: applies the `beats_to_4k` term, so no burst crosses a 4 KB boundary (AXI compliant).
  - Undefined: the term is removed, so `beats = min(beats_left, MAX_BURST)`. This is for DDR controllers known to tolerate crossings, and saves the subtractor.

## Structure
- Shared package `north_gdma_pkg`:
  - `AXI_SIZE_4B = 3'b010` and `AXI_BURST_INCR = 2'b01`.
  - FSM state enum `raddr_state_t` (IDLE, CALC, ADDR).
  - `PAGE_BYTES = 4096`.
- One sub-module, `north_raddr_burst_calc`: pure combinational min/4K computation. Inputs `addr_q`, `beats_left`; output `beats`. The macro is applied inside it.

## Test plan
- `base=0x1000`, `length=0x3C` (16 beats), `arready` tied 1 → one burst, `araddr=0x1000`, `arlen=15`; `gdma_addr_done` rises the cycle after the handshake.
- `base=0x0FF0`, `length=0x1C` (8 beats), macro defined → bursts (0x0FF0, len 3) and (0x1000, len 3). With the macro undefined → a single burst (0x0FF0, len 7).
- `base=0`, `length=0x1FC` (128 beats), `MAX_OUTSTANDING=4`, no `rlast` → exactly 4 bursts of `arlen=15`, then `arvalid` stays low. One `rlast` → the 5th burst issues 2 cycles later.
- `arready` held low for 10 cycles → `arvalid`, `araddr` and `arlen` stay constant; a second `op_start` in that window is ignored.
- AR handshake and `rlast` in the same cycle with outstanding=2 → outstanding stays 2. A stray `rlast` at 0 → stays 0.
- `rst_n` asserted while `arvalid=1` → `arvalid=0` and `gdma_addr_done=1` asynchronously; after release, a new `op_start` runs normally.
